// File: rtl/c64_keyboard_matrix_if.sv
// CIA1 port A/B bus between the CIA and the keyboard/joystick matrix.
// The CIA drives the column/row levels; the matrix returns the pulled-down inputs.
interface c64_keyboard_matrix_if;
    logic [7:0] pa_out;
    logic [7:0] pb_out;
    logic [7:0] pa_in;
    logic [7:0] pb_in;

    modport master (
        output pa_out,
        output pb_out,
        input  pa_in,
        input  pb_in
    );

    modport slave (
        input  pa_out,
        input  pb_out,
        output pa_in,
        output pb_in
    );
endinterface

// File: rtl/c64_keyboard_matrix.sv
// C64 8x8 keyboard matrix and joystick ports on CIA1, fed by PS/2 key events.
// Also produces the active-low RESTORE pulse for the NMI logic.
module c64_keyboard_matrix #(
    parameter int RESTORE_PULSE = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           ps2_key,
    input  logic [4:0]            joy_a,
    input  logic [4:0]            joy_b,
    c64_keyboard_matrix_if.slave  cia,
    output logic                  restore_n
);

    localparam int CW = $clog2(RESTORE_PULSE + 1);

    localparam logic [1:0] SP_NONE    = 2'd0;
    localparam logic [1:0] SP_CAPS    = 2'd1;
    localparam logic [1:0] SP_RESTORE = 2'd2;

    localparam int LSHIFT_IDX = 15;

    // ROM entry: {valid, pa_idx[2:0], pb_idx[2:0], force_shift, special[1:0]}
    function automatic logic [9:0] key_at(input int pa, input int pb);
        return {1'b1, pa[2:0], pb[2:0], 1'b0, SP_NONE};
    endfunction

    function automatic logic [9:0] shift_at(input int pa, input int pb);
        return {1'b1, pa[2:0], pb[2:0], 1'b1, SP_NONE};
    endfunction

    // Positional C64 layout keyed by {E0-extended, scan code}.
    function automatic logic [9:0] map_key(input logic [8:0] k);
        logic [9:0] m;
        m = '0;
        case (k)
            9'h066: m = key_at(0, 0);
            9'h05A: m = key_at(0, 1);
            9'h15A: m = key_at(0, 1);
            9'h174: m = key_at(0, 2);
            9'h16B: m = shift_at(0, 2);
            9'h083: m = key_at(0, 3);
            9'h005: m = key_at(0, 4);
            9'h004: m = key_at(0, 5);
            9'h003: m = key_at(0, 6);
            9'h172: m = key_at(0, 7);
            9'h175: m = shift_at(0, 7);
            9'h026: m = key_at(1, 0);
            9'h01D: m = key_at(1, 1);
            9'h01C: m = key_at(1, 2);
            9'h025: m = key_at(1, 3);
            9'h01A: m = key_at(1, 4);
            9'h01B: m = key_at(1, 5);
            9'h024: m = key_at(1, 6);
            9'h012: m = key_at(1, 7);
            9'h02E: m = key_at(2, 0);
            9'h02D: m = key_at(2, 1);
            9'h023: m = key_at(2, 2);
            9'h036: m = key_at(2, 3);
            9'h021: m = key_at(2, 4);
            9'h02B: m = key_at(2, 5);
            9'h02C: m = key_at(2, 6);
            9'h022: m = key_at(2, 7);
            9'h03D: m = key_at(3, 0);
            9'h035: m = key_at(3, 1);
            9'h034: m = key_at(3, 2);
            9'h03E: m = key_at(3, 3);
            9'h032: m = key_at(3, 4);
            9'h033: m = key_at(3, 5);
            9'h03C: m = key_at(3, 6);
            9'h02A: m = key_at(3, 7);
            9'h046: m = key_at(4, 0);
            9'h043: m = key_at(4, 1);
            9'h03B: m = key_at(4, 2);
            9'h045: m = key_at(4, 3);
            9'h03A: m = key_at(4, 4);
            9'h042: m = key_at(4, 5);
            9'h044: m = key_at(4, 6);
            9'h031: m = key_at(4, 7);
            9'h04E: m = key_at(5, 0);
            9'h04D: m = key_at(5, 1);
            9'h04B: m = key_at(5, 2);
            9'h055: m = key_at(5, 3);
            9'h049: m = key_at(5, 4);
            9'h04C: m = key_at(5, 5);
            9'h054: m = key_at(5, 6);
            9'h041: m = key_at(5, 7);
            9'h170: m = key_at(6, 0);
            9'h05B: m = key_at(6, 1);
            9'h052: m = key_at(6, 2);
            9'h16C: m = key_at(6, 3);
            9'h059: m = key_at(6, 4);
            9'h05D: m = key_at(6, 5);
            9'h171: m = key_at(6, 6);
            9'h04A: m = key_at(6, 7);
            9'h016: m = key_at(7, 0);
            9'h00E: m = key_at(7, 1);
            9'h00D: m = key_at(7, 2);
            9'h01E: m = key_at(7, 3);
            9'h029: m = key_at(7, 4);
            9'h014: m = key_at(7, 5);
            9'h015: m = key_at(7, 6);
            9'h076: m = key_at(7, 7);
            9'h058: m = {1'b1, 6'd0, 1'b0, SP_CAPS};
            9'h17D: m = {1'b1, 6'd0, 1'b0, SP_RESTORE};
            default: m = '0;
        endcase
        return m;
    endfunction

    logic          tog_q;
    logic          armed;
    logic [63:0]   key_state;
    logic [63:0]   fs_key;
    logic          shift_lock;
    logic [CW-1:0] rst_cnt;

    logic [9:0] ent;
    logic       ent_valid;
    logic [5:0] ent_idx;
    logic       ent_fs;
    logic [1:0] ent_sp;
    logic       press;
    logic       evt;

    assign ent       = map_key(ps2_key[8:0]);
    assign ent_valid = ent[9];
    assign ent_idx   = ent[8:3];
    assign ent_fs    = ent[2];
    assign ent_sp    = ent[1:0];
    assign press     = ps2_key[9];
    assign evt       = armed && (ps2_key[10] != tog_q);

    // First edge after reset only latches the toggle; later edges detect flips.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tog_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            if (!armed || evt)
                tog_q <= ps2_key[10];
        end
    end

    // Plain keys land in key_state; forced-shift keys keep their own bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_state  <= '0;
            fs_key     <= '0;
            shift_lock <= 1'b0;
        end else if (evt && ent_valid) begin
            if (ent_sp == SP_CAPS) begin
                if (press)
                    shift_lock <= ~shift_lock;
            end else if (ent_sp == SP_NONE) begin
                if (ent_fs)
                    fs_key[ent_idx] <= press;
                else
                    key_state[ent_idx] <= press;
            end
        end
    end

    // RESTORE pulse counter; a press while counting is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rst_cnt <= '0;
        else if (evt && ent_valid && press && ent_sp == SP_RESTORE
                 && rst_cnt == '0)
            rst_cnt <= CW'(RESTORE_PULSE);
        else if (rst_cnt != '0)
            rst_cnt <= rst_cnt - 1'b1;
    end

    assign restore_n = (rst_cnt == '0);

    logic [63:0] kmat;
    logic [7:0]  pa_eff;
    logic [7:0]  pb_eff;
    logic [7:0]  pa_next;
    logic [7:0]  pb_next;

    // Single-pass wired-AND matrix: a closed key pulls the opposite line low.
    always_comb begin
        kmat = key_state | fs_key;
        kmat[LSHIFT_IDX] = key_state[LSHIFT_IDX] | shift_lock | (|fs_key);
        pa_eff  = cia.pa_out & ~{3'b000, joy_a};
        pb_eff  = cia.pb_out & ~{3'b000, joy_b};
        pa_next = pa_eff;
        pb_next = pb_eff;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                if (kmat[{a[2:0], b[2:0]}] && !pa_eff[a])
                    pb_next[b] = 1'b0;
                if (kmat[{a[2:0], b[2:0]}] && !pb_eff[b])
                    pa_next[a] = 1'b0;
            end
        end
    end

    // Port inputs are registered once per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cia.pa_in <= 8'hFF;
            cia.pb_in <= 8'hFF;
        end else begin
            cia.pa_in <= pa_next;
            cia.pb_in <= pb_next;
        end
    end

endmodule

// File: tb/tb_c64_keyboard_matrix.sv
// Directed bench for c64_keyboard_matrix with a scoreboard of expected
// {pa_in, pb_in, restore_n} snapshots and restore pulse lengths.
module tb_c64_keyboard_matrix;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [4:0]  joy_a = '0;
    logic [4:0]  joy_b = '0;
    logic        restore_n;

    c64_keyboard_matrix_if cia ();

    c64_keyboard_matrix #(.RESTORE_PULSE(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_key   (ps2_key),
        .joy_a     (joy_a),
        .joy_b     (joy_b),
        .cia       (cia),
        .restore_n (restore_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic tog = 1'b1;
    int   lows;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic press, input logic [8:0] k);
        tog = ~tog;
        ps2_key = {tog, press, k};
    endtask

    task automatic expect_io(input string tag, input logic [7:0] pa,
                             input logic [7:0] pb, input logic rn);
        exp_t e;
        e.tag = tag;
        e.val = {15'b0, pa, pb, rn};
        sb.push_back(e);
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: observed %h required an entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic check_io();
        check({15'b0, cia.pa_in, cia.pb_in, restore_n});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        // reset with garbage inputs and a pending toggle value
        cia.pa_out = 8'h00;
        cia.pb_out = 8'h00;
        joy_a = 5'h1F;
        joy_b = 5'h1F;
        ps2_key = {1'b1, 1'b1, 9'h01C};
        expect_io("rst_hold", 8'hFF, 8'hFF, 1'b1);
        cyc(3);
        check_io();

        // first edge only arms: the stale toggle must not press A
        joy_a = '0;
        joy_b = '0;
        cia.pa_out = 8'hFD;
        cia.pb_out = 8'hFF;
        reset = 1'b0;
        expect_io("arm_no_action", 8'hFD, 8'hFF, 1'b1);
        cyc(2);
        check_io();

        // press A: visible two edges after the event
        send(1'b1, 9'h01C);
        expect_io("a_lat1", 8'hFD, 8'hFF, 1'b1);
        cyc(1);
        check_io();
        expect_io("a_press", 8'hFD, 8'hFB, 1'b1);
        cyc(1);
        check_io();

        send(1'b1, 9'h01C);
        expect_io("a_repeat", 8'hFD, 8'hFB, 1'b1);
        cyc(2);
        check_io();

        // reverse scan
        cia.pa_out = 8'hFF;
        cia.pb_out = 8'hFB;
        expect_io("rev_scan", 8'hFD, 8'hFB, 1'b1);
        cyc(1);
        check_io();
        cia.pb_out = 8'hFF;
        expect_io("rev_idle", 8'hFF, 8'hFF, 1'b1);
        cyc(1);
        check_io();

        cia.pa_out = 8'hFD;
        send(1'b0, 9'h01C);
        expect_io("a_release", 8'hFD, 8'hFF, 1'b1);
        cyc(2);
        check_io();

        // A and S share column PA1
        send(1'b1, 9'h01C);
        cyc(1);
        send(1'b1, 9'h01B);
        expect_io("wired_and", 8'hFD, 8'hDB, 1'b1);
        cyc(2);
        check_io();
        send(1'b0, 9'h01C);
        cyc(1);
        send(1'b0, 9'h01B);
        expect_io("wired_rel", 8'hFD, 8'hFF, 1'b1);
        cyc(2);
        check_io();

        // cursor up: PB7 on PA0 plus forced left shift
        cia.pa_out = 8'hFE;
        send(1'b1, 9'h175);
        expect_io("up_col0", 8'hFE, 8'h7F, 1'b1);
        cyc(2);
        check_io();
        cia.pa_out = 8'hFD;
        expect_io("up_shift", 8'hFD, 8'h7F, 1'b1);
        cyc(1);
        check_io();
        send(1'b0, 9'h175);
        expect_io("up_rel", 8'hFD, 8'hFF, 1'b1);
        cyc(2);
        check_io();
        cia.pa_out = 8'hFF;
        expect_io("up_idle", 8'hFF, 8'hFF, 1'b1);
        cyc(1);
        check_io();

        // cursor down must not force shift
        cia.pa_out = 8'hFD;
        send(1'b1, 9'h172);
        expect_io("dn_noshift", 8'hFD, 8'hFF, 1'b1);
        cyc(2);
        check_io();
        cia.pa_out = 8'hFE;
        expect_io("dn_col0", 8'hFE, 8'h7F, 1'b1);
        cyc(1);
        check_io();
        send(1'b0, 9'h172);
        cyc(2);

        // caps lock toggles on press only
        cia.pa_out = 8'hFD;
        send(1'b1, 9'h058);
        cyc(1);
        send(1'b0, 9'h058);
        expect_io("caps_on", 8'hFD, 8'h7F, 1'b1);
        cyc(2);
        check_io();
        send(1'b1, 9'h058);
        expect_io("caps_off", 8'hFD, 8'hFF, 1'b1);
        cyc(2);
        check_io();
        send(1'b0, 9'h058);
        cyc(2);

        // joystick ghost through Return
        cia.pa_out = 8'hFF;
        send(1'b1, 9'h05A);
        joy_a = 5'h01;
        expect_io("joy_ghost", 8'hFE, 8'hFD, 1'b1);
        cyc(2);
        check_io();
        joy_a = 5'h00;
        expect_io("joy_clear", 8'hFF, 8'hFF, 1'b1);
        cyc(1);
        check_io();
        send(1'b0, 9'h05A);
        joy_b = 5'h10;
        expect_io("joy_b_fire", 8'hFF, 8'hEF, 1'b1);
        cyc(2);
        check_io();
        joy_b = 5'h00;

        // unmapped code is ignored
        cia.pa_out = 8'h00;
        send(1'b1, 9'h0FE);
        expect_io("invalid", 8'h00, 8'hFF, 1'b1);
        cyc(2);
        check_io();
        cia.pa_out = 8'hFF;
        cyc(1);

        // restore pulse length, second press mid-pulse ignored
        send(1'b1, 9'h17D);
        expect_val("restore_len", 32'd16);
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (!restore_n)
                lows++;
            if (i == 3)
                send(1'b0, 9'h17D);
            if (i == 6)
                send(1'b1, 9'h17D);
        end
        check(32'(lows));
        send(1'b0, 9'h17D);
        cyc(2);

        // reset mid-operation with key held and pulse running
        cia.pa_out = 8'hFD;
        send(1'b1, 9'h01C);
        expect_io("rst_pre", 8'hFD, 8'hFB, 1'b1);
        cyc(2);
        check_io();
        send(1'b1, 9'h17D);
        expect_io("restore_running", 8'hFD, 8'hFB, 1'b0);
        cyc(3);
        check_io();
        reset = 1'b1;
        #1;
        expect_io("rst_mid", 8'hFF, 8'hFF, 1'b1);
        check_io();
        expect_io("rst_mid_hold", 8'hFF, 8'hFF, 1'b1);
        cyc(2);
        check_io();
        reset = 1'b0;
        expect_io("rst_key_lost", 8'hFD, 8'hFF, 1'b1);
        cyc(2);
        check_io();
        send(1'b1, 9'h01C);
        expect_io("post_rst_press", 8'hFD, 8'hFB, 1'b1);
        cyc(2);
        check_io();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
